// File: rtl/fattree_endpoint_ni.sv
// Fat-tree endpoint network interface: packetizes core TX traffic with credit metering and
// depacketizes RX traffic through a B-deep FIFO. Optional FATTREE_NI_DST_CHECK_EN adds a sticky dst-mismatch flag.
module fattree_endpoint_ni #(
  parameter int K     = 2,
  parameter int L     = 2,
  parameter int Fpay  = 32,
  parameter int B     = 4,
  parameter int MY_ID = 0,
  localparam int Kw   = $clog2(K),
  localparam int EAw  = L * Kw,
  localparam int Fw   = Fpay + 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tx_valid,
  output logic           tx_ready,
  input  logic [Fpay-1:0] tx_data,
  input  logic           tx_last,
  input  logic [EAw-1:0] tx_dest,
  output logic [Fw-1:0]  flit_out,
  output logic           flit_out_wr,
  input  logic           credit_in,
  input  logic [Fw-1:0]  flit_in,
  input  logic           flit_in_wr,
  output logic           credit_out,
  output logic           rx_valid,
  input  logic           rx_ready,
  output logic [Fpay-1:0] rx_data,
  output logic           rx_last,
  output logic [EAw-1:0] rx_src,
  output logic           err
);

  localparam int Cw = $clog2(B + 1);
  localparam int Aw = (B > 1) ? $clog2(B) : 1;

  // Base-K digit i of the index lands in bits [i*Kw +: Kw].
  function automatic logic [EAw-1:0] encode(input int idx);
    logic [EAw-1:0] addr;
    addr = '0;
    for (int i = 0; i < L; i++) begin
      addr[i*Kw +: Kw] = Kw'((idx >> (i * Kw)) & (K - 1));
    end
    return addr;
  endfunction

  localparam logic [EAw-1:0] MY_ADDR = encode(MY_ID);

  typedef enum logic {TX_IDLE, TX_BODY} tx_state_t;

  tx_state_t       tx_state, tx_state_next;
  logic [Cw-1:0]   credits;
  logic            can_send;
  logic            load_hdr;
  logic            load_body;
  logic            send;
  logic [Fpay-1:0] hdr_payload;

  assign can_send    = (credits != '0);
  assign send        = load_hdr || load_body;
  assign hdr_payload = Fpay'({MY_ADDR, encode(int'(tx_dest))});

  always_ff @(posedge clk) begin
    if (reset) tx_state <= TX_IDLE;
    else       tx_state <= tx_state_next;
  end

  always_comb begin
    tx_state_next = tx_state;
    tx_ready      = 1'b0;
    load_hdr      = 1'b0;
    load_body     = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (tx_valid && can_send) begin
          load_hdr      = 1'b1;
          tx_state_next = TX_BODY;
        end
      end
      TX_BODY: begin
        tx_ready = tx_valid && can_send;
        if (tx_ready) begin
          load_body = 1'b1;
          if (tx_last) tx_state_next = TX_IDLE;
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flit_out    <= '0;
      flit_out_wr <= 1'b0;
    end else begin
      flit_out_wr <= send;
      if (load_hdr)       flit_out <= {1'b1, 1'b0, hdr_payload};
      else if (load_body) flit_out <= {1'b0, tx_last, tx_data};
    end
  end

  // Charged at the send decision so the count already reflects a flit in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      credits <= Cw'(B);
    end else begin
      case ({send, credit_in})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   if (credits != Cw'(B)) credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  logic [Fw-1:0] fifo_mem [B];
  logic [Aw-1:0] rd_ptr, wr_ptr;
  logic [Cw-1:0] fifo_count;
  logic [Fw-1:0] head;
  logic          head_valid;
  logic          head_hdr;
  logic          push;
  logic          pop;

  assign head       = fifo_mem[rd_ptr];
  assign head_valid = (fifo_count != '0);
  assign head_hdr   = head[Fw-1];
  assign pop        = head_valid && (head_hdr || rx_ready);
  assign push       = flit_in_wr && ((fifo_count != Cw'(B)) || pop);

  assign rx_valid = head_valid && !head_hdr;
  assign rx_data  = rx_valid ? head[Fpay-1:0] : '0;
  assign rx_last  = rx_valid && head[Fw-2];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= flit_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == Aw'(B - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == Aw'(B - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      credit_out <= 1'b0;
      rx_src     <= '0;
    end else begin
      credit_out <= pop;
      if (pop && head_hdr) rx_src <= head[2*EAw-1:EAw];
    end
  end

`ifdef FATTREE_NI_DST_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset)                                            err <= 1'b0;
    else if (pop && head_hdr && head[EAw-1:0] != MY_ADDR) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fattree_endpoint_ni.sv
// Directed bench: dut_a (K=2,L=3,B=4,MY_ID=2) for TX/RX paths, dut_b (K=4,L=2,B=2) for encoding and credit stall.
module tb_fattree_endpoint_ni;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        a_tx_valid, a_tx_ready, a_tx_last, a_flit_out_wr, a_credit_in, a_flit_in_wr;
  logic        a_credit_out, a_rx_valid, a_rx_ready, a_rx_last, a_err;
  logic [31:0] a_tx_data, a_rx_data;
  logic [2:0]  a_tx_dest, a_rx_src;
  logic [33:0] a_flit_out, a_flit_in;

  logic        b_tx_valid, b_tx_ready, b_tx_last, b_flit_out_wr, b_credit_in, b_flit_in_wr;
  logic        b_credit_out, b_rx_valid, b_rx_ready, b_rx_last, b_err;
  logic [31:0] b_tx_data, b_rx_data;
  logic [3:0]  b_tx_dest, b_rx_src;
  logic [33:0] b_flit_out, b_flit_in;

  fattree_endpoint_ni #(.K(2), .L(3), .Fpay(32), .B(4), .MY_ID(2)) dut_a (
    .clk(clk), .reset(reset),
    .tx_valid(a_tx_valid), .tx_ready(a_tx_ready), .tx_data(a_tx_data), .tx_last(a_tx_last),
    .tx_dest(a_tx_dest), .flit_out(a_flit_out), .flit_out_wr(a_flit_out_wr), .credit_in(a_credit_in),
    .flit_in(a_flit_in), .flit_in_wr(a_flit_in_wr), .credit_out(a_credit_out),
    .rx_valid(a_rx_valid), .rx_ready(a_rx_ready), .rx_data(a_rx_data), .rx_last(a_rx_last),
    .rx_src(a_rx_src), .err(a_err)
  );

  fattree_endpoint_ni #(.K(4), .L(2), .Fpay(32), .B(2), .MY_ID(0)) dut_b (
    .clk(clk), .reset(reset),
    .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .tx_data(b_tx_data), .tx_last(b_tx_last),
    .tx_dest(b_tx_dest), .flit_out(b_flit_out), .flit_out_wr(b_flit_out_wr), .credit_in(b_credit_in),
    .flit_in(b_flit_in), .flit_in_wr(b_flit_in_wr), .credit_out(b_credit_out),
    .rx_valid(b_rx_valid), .rx_ready(b_rx_ready), .rx_data(b_rx_data), .rx_last(b_rx_last),
    .rx_src(b_rx_src), .err(b_err)
  );

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance past the next rising edge so registered outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    a_tx_valid = 0; a_tx_data = '0; a_tx_last = 0; a_tx_dest = '0; a_credit_in = 0;
    a_flit_in = '0; a_flit_in_wr = 0; a_rx_ready = 0;
    b_tx_valid = 0; b_tx_data = '0; b_tx_last = 0; b_tx_dest = '0; b_credit_in = 0;
    b_flit_in = '0; b_flit_in_wr = 0; b_rx_ready = 0;
    repeat (3) tick();
    check_output("rst_flit_out", 64'(a_flit_out), 64'd0);
    check_output("rst_flit_out_wr", 64'(a_flit_out_wr), 64'd0);
    check_output("rst_credit_out", 64'(a_credit_out), 64'd0);
    check_output("rst_rx_valid", 64'(a_rx_valid), 64'd0);
    check_output("rst_rx_data", 64'(a_rx_data), 64'd0);
    check_output("rst_rx_last", 64'(a_rx_last), 64'd0);
    check_output("rst_rx_src", 64'(a_rx_src), 64'd0);
    check_output("rst_err", 64'(a_err), 64'd0);
    check_output("rst_tx_ready", 64'(a_tx_ready), 64'd0);
    reset = 1'b0;

    // Packet to 5 from 2: header, then 0xA,0xB,0xC back to back with no credit_in.
    a_tx_valid = 1; a_tx_dest = 3'd5; a_tx_data = 32'hA; a_tx_last = 0;
    #1 check_output("idle_tx_ready", 64'(a_tx_ready), 64'd0);
    tick();
    check_output("hdr_wr", 64'(a_flit_out_wr), 64'd1);
    check_output("hdr_flit", 64'(a_flit_out), 64'({1'b1, 1'b0, 32'h15}));
    check_output("body_tx_ready", 64'(a_tx_ready), 64'd1);
    tick();
    check_output("body_a", 64'(a_flit_out), 64'({1'b0, 1'b0, 32'hA}));
    a_tx_data = 32'hB;
    tick();
    check_output("body_b", 64'(a_flit_out), 64'({1'b0, 1'b0, 32'hB}));
    check_output("body_b_wr", 64'(a_flit_out_wr), 64'd1);
    a_tx_data = 32'hC; a_tx_last = 1;
    #1 check_output("fourth_flit_ready", 64'(a_tx_ready), 64'd1);
    tick();
    check_output("body_c_tail", 64'(a_flit_out), 64'({1'b0, 1'b1, 32'hC}));
    a_tx_valid = 0; a_tx_last = 0;
    #1 check_output("after_tail_ready", 64'(a_tx_ready), 64'd0);
    tick();
    check_output("gap_wr", 64'(a_flit_out_wr), 64'd0);

    // Credits exhausted: a new packet must wait for credit_in.
    a_tx_valid = 1; a_tx_dest = 3'd1; a_tx_data = 32'hE;
    tick();
    check_output("zero_credit_wr", 64'(a_flit_out_wr), 64'd0);
    a_credit_in = 1;
    tick();
    check_output("credit_arrive_wr", 64'(a_flit_out_wr), 64'd0);
    a_credit_in = 0;
    tick();
    check_output("hdr2_wr", 64'(a_flit_out_wr), 64'd1);
    check_output("hdr2_flit", 64'(a_flit_out), 64'({1'b1, 1'b0, 32'h11}));
    check_output("hdr2_stall_ready", 64'(a_tx_ready), 64'd0);
    a_credit_in = 1;
    tick();
    check_output("stall_wr", 64'(a_flit_out_wr), 64'd0);
    check_output("count1_ready", 64'(a_tx_ready), 64'd1);
    tick();
    check_output("simul_flit", 64'(a_flit_out), 64'({1'b0, 1'b0, 32'hE}));
    a_credit_in = 0; a_tx_data = 32'hD; a_tx_last = 1;
    #1 check_output("simul_no_stall", 64'(a_tx_ready), 64'd1);
    tick();
    check_output("simul_tail", 64'(a_flit_out), 64'({1'b0, 1'b1, 32'hD}));
    check_output("simul_tail_wr", 64'(a_flit_out_wr), 64'd1);
    a_tx_valid = 0; a_tx_last = 0;

    // RX: header from 3 to 2, then two bodies held back by rx_ready=0.
    a_flit_in = {1'b1, 1'b0, 32'h1A}; a_flit_in_wr = 1;
    tick();
    a_flit_in = {1'b0, 1'b0, 32'h111};
    #1 check_output("rx_hdr_hidden", 64'(a_rx_valid), 64'd0);
    tick();
    check_output("rx_src", 64'(a_rx_src), 64'd3);
    check_output("rx_hdr_credit", 64'(a_credit_out), 64'd1);
    check_output("rx_body1_valid", 64'(a_rx_valid), 64'd1);
    check_output("rx_body1_data", 64'(a_rx_data), 64'h111);
    a_flit_in = {1'b0, 1'b1, 32'h222};
    tick();
    a_flit_in_wr = 0;
    check_output("rx_one_credit", 64'(a_credit_out), 64'd0);
    tick();
    check_output("rx_held_data", 64'(a_rx_data), 64'h111);
    check_output("rx_held_last", 64'(a_rx_last), 64'd0);
    a_rx_ready = 1;
    tick();
    check_output("rx_pop1_credit", 64'(a_credit_out), 64'd1);
    check_output("rx_body2_data", 64'(a_rx_data), 64'h222);
    check_output("rx_body2_last", 64'(a_rx_last), 64'd1);
    tick();
    check_output("rx_pop2_credit", 64'(a_credit_out), 64'd1);
    check_output("rx_empty", 64'(a_rx_valid), 64'd0);
    tick();
    check_output("rx_credit_done", 64'(a_credit_out), 64'd0);
    check_output("rx_err_match", 64'(a_err), 64'd0);

`ifdef FATTREE_NI_DST_CHECK_EN
    // Header addressed to 5 from 1 arriving at endpoint 2.
    a_flit_in = {1'b1, 1'b0, 32'h0D}; a_flit_in_wr = 1;
    tick();
    a_flit_in = {1'b0, 1'b1, 32'h333};
    tick();
    a_flit_in_wr = 0;
    check_output("err_set", 64'(a_err), 64'd1);
    check_output("err_pkt_src", 64'(a_rx_src), 64'd1);
    check_output("err_pkt_data", 64'(a_rx_data), 64'h333);
    tick();
    check_output("err_sticky", 64'(a_err), 64'd1);
    check_output("err_pkt_drained", 64'(a_rx_valid), 64'd0);
`endif

    // dut_b: K=4 encoding and B=2 credit stall.
    b_tx_valid = 1; b_tx_dest = 4'd6; b_tx_data = 32'h1; b_tx_last = 0;
    tick();
    check_output("b_hdr_dst", 64'(b_flit_out[3:0]), 64'b0110);
    check_output("b_hdr_flit", 64'(b_flit_out), 64'({1'b1, 1'b0, 32'h06}));
    tick();
    check_output("b_body1", 64'(b_flit_out), 64'({1'b0, 1'b0, 32'h1}));
    check_output("b_stall_ready", 64'(b_tx_ready), 64'd0);
    b_tx_data = 32'h2; b_tx_last = 1;
    tick();
    check_output("b_stall_wr", 64'(b_flit_out_wr), 64'd0);
    b_credit_in = 1;
    tick();
    b_credit_in = 0;
    check_output("b_credit_wr", 64'(b_flit_out_wr), 64'd0);
    check_output("b_credit_ready", 64'(b_tx_ready), 64'd1);
    tick();
    b_tx_valid = 0; b_tx_last = 0;
    check_output("b_release_wr", 64'(b_flit_out_wr), 64'd1);
    check_output("b_release_flit", 64'(b_flit_out), 64'({1'b0, 1'b1, 32'h2}));
    tick();
    check_output("b_one_only", 64'(b_flit_out_wr), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
